// File: rtl/frame_buf_sched_pkg.sv
// ---------------------------------------------------------------------------
// frame_buf_sched_pkg
// Shared types and defaults for the double-buffered frame scheduler:
//   bank_state_e : per-bank life cycle FREE -> WRITING -> FULL -> READING
//   wr_state_e   : writer FSM states
//   dbg_t        : debug view of the writer FSM and both bank states
//   sat_add8     : saturating 8-bit add used by the frame/error counters
// ---------------------------------------------------------------------------
package frame_buf_sched_pkg;

   localparam int ADDR_W_DEFAULT  = 16;
   localparam int PIX_NUM_DEFAULT = 57600;   // 240 x 240

   typedef enum logic [1:0] {
      BANK_FREE    = 2'd0,
      BANK_WRITING = 2'd1,
      BANK_FULL    = 2'd2,
      BANK_READING = 2'd3
   } bank_state_e;

   typedef enum logic {
      W_IDLE = 1'b0,
      W_WR   = 1'b1
   } wr_state_e;

   typedef struct packed {
      wr_state_e   wr_state;
      bank_state_e bank1;
      bank_state_e bank0;
   } dbg_t;

   // A single cycle can add up to two errors (abort of the running frame plus
   // a rejected one-pixel frame), hence the 2-bit increment.
   function automatic logic [7:0] sat_add8(input logic [7:0] v, input logic [1:0] n);
      logic [8:0] s;
      s = {1'b0, v} + {7'b0, n};
      return s[8] ? 8'hFF : s[7:0];
   endfunction

endpackage

// File: rtl/frame_buf_sched_bank_state_reg.sv
// ---------------------------------------------------------------------------
// bank_state_reg
// Holds the state of both frame-buffer banks and applies the reader and
// writer transitions decided by the top level.
//   clk, rst        : clock, synchronous active-high reset (banks -> FREE)
//   rd_switch_i     : reader takes rd_bank_i (FULL -> READING); the bank
//                     previously READING is released to FREE
//   rd_bank_i       : bank the reader switches to
//   wr_set_i        : writer updates bank wr_bank_i to wr_state_i
//   bank0_st_o/1    : registered bank states
// The writer update is applied last. The top level guarantees it never
// targets the bank the reader is taking, so the only overlap is the released
// READING bank being claimed by a new frame, where WRITING must win.
// ---------------------------------------------------------------------------
module bank_state_reg
   import frame_buf_sched_pkg::*;
(
   input  logic        clk,
   input  logic        rst,
   input  logic        rd_switch_i,
   input  logic        rd_bank_i,
   input  logic        wr_set_i,
   input  logic        wr_bank_i,
   input  bank_state_e wr_state_i,
   output bank_state_e bank0_st_o,
   output bank_state_e bank1_st_o
);

   bank_state_e st_q [2];
   bank_state_e st_d [2];

   always_comb begin
      st_d[0] = st_q[0];
      st_d[1] = st_q[1];
      if (rd_switch_i) begin
         if (st_q[~rd_bank_i] == BANK_READING) st_d[~rd_bank_i] = BANK_FREE;
         st_d[rd_bank_i] = BANK_READING;
      end
      if (wr_set_i) st_d[wr_bank_i] = wr_state_i;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         st_q[0] <= BANK_FREE;
         st_q[1] <= BANK_FREE;
      end else begin
         st_q[0] <= st_d[0];
         st_q[1] <= st_d[1];
      end
   end

   assign bank0_st_o = st_q[0];
   assign bank1_st_o = st_q[1];

endmodule

// File: rtl/frame_buf_sched.sv
// ---------------------------------------------------------------------------
// frame_buf_sched
// Schedules binary edge frames from the sobel stage into a two-bank frame
// buffer and hands completed frames to the VGA read side.
//   clk, rst                   : clock, synchronous active-high reset
//   din, din_vld/sop/eop       : pixel stream with frame delimiters
//   rd_start                   : VGA start-of-frame pulse
//   wr_en/wr_bank/wr_addr/
//   wr_data                    : registered RAM write port (1 cycle latency)
//   rd_bank                    : bank the VGA side reads
//   frame_rdy                  : sticky, set at the first bank hand-over
//   frame_cnt / err_cnt        : saturating accepted / discarded frames
//   dbg_o                      : writer FSM state and both bank states
// Handshake: a pixel is consumed in every cycle din_vld is high; there is no
// back-pressure. In W_IDLE only a din_sop pixel is consumed, others dropped.
// ---------------------------------------------------------------------------
module frame_buf_sched
   import frame_buf_sched_pkg::*;
#(
   parameter int ADDR_W  = ADDR_W_DEFAULT,
   parameter int PIX_NUM = PIX_NUM_DEFAULT
)(
   input  logic              clk,
   input  logic              rst,
   input  logic              din,
   input  logic              din_vld,
   input  logic              din_sop,
   input  logic              din_eop,
   input  logic              rd_start,
   output logic              wr_en,
   output logic              wr_bank,
   output logic [ADDR_W-1:0] wr_addr,
   output logic              wr_data,
   output logic              rd_bank,
   output logic              frame_rdy,
   output logic [7:0]        frame_cnt,
   output logic [7:0]        err_cnt,
   output dbg_t              dbg_o
);

   // One extra bit so over-long frames keep counting past PIX_NUM; the
   // counter saturates so very long frames can never alias to PIX_NUM.
   localparam int               CNT_W   = ADDR_W + 1;
   localparam logic [CNT_W-1:0] PIX_CNT = CNT_W'(PIX_NUM);

   bank_state_e bank_st [2];
   bank_state_e bank0_st, bank1_st;

   wr_state_e          wr_state_q, wr_state_d;
   logic               wbank_q, wbank_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic               wr_en_q, wr_bank_q, wr_data_q;
   logic [ADDR_W-1:0]  wr_addr_q;
   logic               rd_bank_q, frame_rdy_q;
   logic [7:0]         frame_cnt_q, err_cnt_q;

   logic               rd_busy, rd_cand, rd_switch;
   logic               accept, abort, cur_bank, wr_fire, eop_ok, eop_bad;
   logic [CNT_W-1:0]   idx, cnt_nxt;
   logic               wr_set;
   bank_state_e        wr_set_state;
   logic [1:0]         err_inc;

   assign bank_st[0] = bank0_st;
   assign bank_st[1] = bank1_st;

   // Reader: the candidate is the bank not READING; before the first
   // hand-over neither is, and only bank 0 can have filled at that point.
   always_comb begin
      rd_busy = (bank_st[0] == BANK_READING) || (bank_st[1] == BANK_READING);
      if (bank_st[0] == BANK_READING)      rd_cand = 1'b1;
      else if (bank_st[1] == BANK_READING) rd_cand = 1'b0;
      else                                 rd_cand = (bank_st[0] == BANK_FULL) ? 1'b0 : 1'b1;
      rd_switch = rd_start && (bank_st[rd_cand] == BANK_FULL);
   end

   // Writer. A new frame avoids the bank that is READING after this cycle's
   // hand-over, so a simultaneous rd_start and sop never collide.
   always_comb begin
      accept  = din_vld && ((wr_state_q == W_WR) || din_sop);
      abort   = din_vld && din_sop && (wr_state_q == W_WR);
      if (wr_state_q == W_WR) cur_bank = wbank_q;
      else if (rd_switch)     cur_bank = ~rd_cand;
      else if (rd_busy)       cur_bank = rd_cand;
      else                    cur_bank = 1'b0;
      idx     = din_sop ? '0 : cnt_q;
      cnt_nxt = (idx == {CNT_W{1'b1}}) ? idx : idx + CNT_W'(1);
      wr_fire = accept && (idx < PIX_CNT);
      eop_ok  = accept && din_eop && (cnt_nxt == PIX_CNT);
      eop_bad = accept && din_eop && (cnt_nxt != PIX_CNT);
      err_inc = {1'b0, abort} + {1'b0, eop_bad};

      wr_set       = accept;
      wr_set_state = BANK_WRITING;
      if (eop_ok)       wr_set_state = BANK_FULL;
      else if (eop_bad) wr_set_state = BANK_FREE;

      wr_state_d = wr_state_q;
      wbank_d    = wbank_q;
      cnt_d      = cnt_q;
      if (accept) begin
         wr_state_d = din_eop ? W_IDLE : W_WR;
         wbank_d    = cur_bank;
         cnt_d      = cnt_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         wr_state_q  <= W_IDLE;
         wbank_q     <= 1'b0;
         cnt_q       <= '0;
         wr_en_q     <= 1'b0;
         wr_bank_q   <= 1'b0;
         wr_addr_q   <= '0;
         wr_data_q   <= 1'b0;
         rd_bank_q   <= 1'b0;
         frame_rdy_q <= 1'b0;
         frame_cnt_q <= 8'd0;
         err_cnt_q   <= 8'd0;
      end else begin
         wr_state_q <= wr_state_d;
         wbank_q    <= wbank_d;
         cnt_q      <= cnt_d;
         wr_en_q    <= wr_fire;
         if (wr_fire) begin
            wr_bank_q <= cur_bank;
            wr_addr_q <= idx[ADDR_W-1:0];
            wr_data_q <= din;
         end
         if (rd_switch) rd_bank_q <= rd_cand;
         frame_rdy_q <= frame_rdy_q | rd_switch;
         frame_cnt_q <= sat_add8(frame_cnt_q, {1'b0, eop_ok});
         err_cnt_q   <= sat_add8(err_cnt_q, err_inc);
      end
   end

   bank_state_reg u_bank_state_reg (
      .clk         (clk),
      .rst         (rst),
      .rd_switch_i (rd_switch),
      .rd_bank_i   (rd_cand),
      .wr_set_i    (wr_set),
      .wr_bank_i   (cur_bank),
      .wr_state_i  (wr_set_state),
      .bank0_st_o  (bank0_st),
      .bank1_st_o  (bank1_st)
   );

   assign wr_en     = wr_en_q;
   assign wr_bank   = wr_bank_q;
   assign wr_addr   = wr_addr_q;
   assign wr_data   = wr_data_q;
   assign rd_bank   = rd_bank_q;
   assign frame_rdy = frame_rdy_q;
   assign frame_cnt = frame_cnt_q;
   assign err_cnt   = err_cnt_q;

   always_comb begin
      dbg_o          = '0;
      dbg_o.wr_state = wr_state_q;
      dbg_o.bank0    = bank0_st;
      dbg_o.bank1    = bank1_st;
   end

endmodule

// File: tb/tb_frame_buf_sched.sv
// ---------------------------------------------------------------------------
// tb_frame_buf_sched
// Drives directed and randomized frames into frame_buf_sched (scaled down to
// a 48-pixel frame) and compares every cycle against a frame-level model.
// ---------------------------------------------------------------------------
module tb_frame_buf_sched;
   import frame_buf_sched_pkg::*;

   localparam int AW = 6;
   localparam int PN = 48;
   localparam int W  = AW + 2;   // {bank, addr, data}

   localparam int S_FREE = 0, S_WRITING = 1, S_FULL = 2, S_READING = 3;

   // ---------------- clock / reset ----------------
   logic          clk = 1'b0;
   logic          rst = 1'b1;
   logic          din = 1'b0, din_vld = 1'b0, din_sop = 1'b0, din_eop = 1'b0, rd_start = 1'b0;
   logic          wr_en, wr_bank, wr_data, rd_bank, frame_rdy;
   logic [AW-1:0] wr_addr;
   logic [7:0]    frame_cnt, err_cnt;
   dbg_t          dbg;

   always #5 clk = ~clk;

   frame_buf_sched #(.ADDR_W(AW), .PIX_NUM(PN)) dut (
      .clk       (clk),
      .rst       (rst),
      .din       (din),
      .din_vld   (din_vld),
      .din_sop   (din_sop),
      .din_eop   (din_eop),
      .rd_start  (rd_start),
      .wr_en     (wr_en),
      .wr_bank   (wr_bank),
      .wr_addr   (wr_addr),
      .wr_data   (wr_data),
      .rd_bank   (rd_bank),
      .frame_rdy (frame_rdy),
      .frame_cnt (frame_cnt),
      .err_cnt   (err_cnt),
      .dbg_o     (dbg)
   );

   // ---------------- checking ----------------
   int n_checks = 0;
   int n_pass   = 0;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
   endtask

   // ---------------- reference model ----------------
   int         m_bank [2];
   bit         m_writing;
   int         m_wbank, m_npix, m_rd_bank, m_fcnt, m_ecnt;
   bit         m_rdy, exp_en;
   logic [W-1:0] exp_q [$];
   bit         rand_rd = 1'b0;

   function automatic int sat(input int v);
      return (v > 255) ? 255 : v;
   endfunction

   function automatic bank_state_e to_enum(input int s);
      case (s)
         S_WRITING: return BANK_WRITING;
         S_FULL:    return BANK_FULL;
         S_READING: return BANK_READING;
         default:   return BANK_FREE;
      endcase
   endfunction

   task automatic model_reset();
      m_bank[0] = S_FREE; m_bank[1] = S_FREE;
      m_writing = 0; m_wbank = 0; m_npix = 0;
      m_rd_bank = 0; m_rdy = 0; m_fcnt = 0; m_ecnt = 0;
      exp_en = 0;
      exp_q.delete();
   endtask

   task automatic model_step(input bit v, input bit s, input bit e, input logic d, input bit r);
      int  reading, cand, ro, tgt, fin;
      bit  sw;
      reading = (m_bank[0] == S_READING) ? 0 : (m_bank[1] == S_READING) ? 1 : -1;
      cand    = (reading >= 0) ? 1 - reading : ((m_bank[0] == S_FULL) ? 0 : 1);
      sw      = r && (m_bank[cand] == S_FULL);
      exp_en  = 0;
      tgt     = -1;
      fin     = S_WRITING;
      if (v && (m_writing || s)) begin
         if (s) begin
            if (m_writing) m_ecnt = sat(m_ecnt + 1);
            else begin
               ro      = sw ? cand : reading;
               m_wbank = (ro >= 0) ? 1 - ro : 0;
            end
            m_npix    = 0;
            m_writing = 1;
         end
         if (m_npix < PN) begin
            exp_en = 1;
            exp_q.push_back({m_wbank[0], m_npix[AW-1:0], d});
         end
         m_npix++;
         if (e) begin
            if (m_npix == PN) begin m_fcnt = sat(m_fcnt + 1); fin = S_FULL; end
            else begin m_ecnt = sat(m_ecnt + 1); fin = S_FREE; end
            m_writing = 0;
         end
         tgt = m_wbank;
      end
      if (sw) begin
         if (reading >= 0) m_bank[reading] = S_FREE;
         m_bank[cand] = S_READING;
         m_rd_bank    = cand;
         m_rdy        = 1;
      end
      if (tgt >= 0) m_bank[tgt] = fin;
   endtask

   task automatic compare_all();
      logic [W-1:0] beat;
      check_eq("wr_en", wr_en, exp_en);
      if (exp_en) begin
         beat = exp_q.pop_front();
         check_eq("wr_beat", {wr_bank, wr_addr, wr_data}, beat);
      end
      check_eq("rd_bank", rd_bank, m_rd_bank);
      check_eq("frame_rdy", frame_rdy, m_rdy);
      check_eq("frame_cnt", frame_cnt, m_fcnt);
      check_eq("err_cnt", err_cnt, m_ecnt);
      check_eq("bank0", dbg.bank0, to_enum(m_bank[0]));
      check_eq("bank1", dbg.bank1, to_enum(m_bank[1]));
      check_eq("wr_state", dbg.wr_state, m_writing ? W_WR : W_IDLE);
   endtask

   // ---------------- driver tasks ----------------
   task automatic cycle(input bit v, input bit s, input bit e, input bit r);
      logic d;
      d        = 1'($urandom_range(0, 1));
      din_vld  = v; din_sop = s; din_eop = e; rd_start = r; din = d;
      if (rst) model_reset();
      else     model_step(v, s, e, d, r);
      @(posedge clk);
      #1;
      compare_all();
      din_vld = 0; din_sop = 0; din_eop = 0; rd_start = 0;
   endtask

   task automatic idle(input int n, input bit r);
      for (int i = 0; i < n; i++) cycle(0, 0, 0, r);
   endtask

   task automatic reset_dut();
      rst = 1'b1;
      idle(2, 0);
      rst = 1'b0;
   endtask

   // resop_at: pixel index carrying an extra sop (-1 for none)
   task automatic send_frame(input int len, input int resop_at, input bit rd_on_eop, input int gap_max);
      int g;
      for (int i = 0; i < len; i++) begin
         g = (gap_max > 0) ? $urandom_range(0, gap_max) : 0;
         for (int k = 0; k < g; k++) cycle(0, 0, 0, rand_rd && ($urandom_range(0, 15) == 0));
         cycle(1, (i == 0) || (i == resop_at), i == len - 1,
               (rd_on_eop && i == len - 1) || (rand_rd && ($urandom_range(0, 31) == 0)));
      end
   endtask

   // ---------------- stimulus ----------------
   initial begin
      int len, rs;
      model_reset();
      reset_dut();
      check_eq("rst_wr_addr", wr_addr, 0);
      check_eq("rst_wr_bank", wr_bank, 0);

      // one full frame then a hand-over
      send_frame(PN, -1, 0, 0);
      cycle(0, 0, 0, 1);
      check_eq("full_fcnt", frame_cnt, 1);
      check_eq("full_rd_bank", rd_bank, 0);
      check_eq("full_rdy", frame_rdy, 1);

      // bank 0 reading, two frames back to back land in bank 1
      send_frame(PN, -1, 0, 0);
      send_frame(PN, -1, 0, 0);
      check_eq("b2b_fcnt", frame_cnt, 3);
      check_eq("b2b_rd_bank", rd_bank, 0);
      cycle(0, 0, 0, 1);
      check_eq("b2b_switch", rd_bank, 1);
      check_eq("b2b_bank0_free", dbg.bank0, BANK_FREE);

      // short frame is discarded and rd_start changes nothing
      send_frame(17, -1, 0, 1);
      check_eq("short_err", err_cnt, 1);
      cycle(0, 0, 0, 1);
      check_eq("short_rd_bank", rd_bank, 1);
      check_eq("short_rdy", frame_rdy, 1);

      // over-long frame, then a frame restarted by a mid-frame sop
      send_frame(PN + 12, -1, 0, 0);
      check_eq("long_err", err_cnt, 2);
      send_frame(PN + 10, 10, 0, 0);
      check_eq("resop_err", err_cnt, 3);
      check_eq("resop_fcnt", frame_cnt, 4);

      // eop and rd_start together: hand-over waits for the next rd_start
      send_frame(PN, -1, 1, 0);
      check_eq("eop_rd_same", rd_bank, 1);
      cycle(0, 0, 0, 1);
      check_eq("eop_rd_next", rd_bank, 0);

      // reset in the middle of a frame, tail ignored, then a clean frame
      send_frame(30, -1, 0, 0);
      reset_dut();
      for (int i = 30; i < PN; i++) cycle(1, 0, i == PN - 1, 0);
      send_frame(PN, -1, 0, 0);
      check_eq("rst_mid_err", err_cnt, 0);
      check_eq("rst_mid_fcnt", frame_cnt, 1);

      // randomized traffic with random hand-overs
      rand_rd = 1'b1;
      for (int f = 0; f < 40; f++) begin
         case ($urandom_range(0, 4))
            0, 1:    len = PN;
            2:       len = PN + ($urandom_range(0, 1) ? 1 : -1);
            default: len = $urandom_range(1, PN + 8);
         endcase
         rs = ($urandom_range(0, 5) == 0) ? $urandom_range(1, PN) : -1;
         send_frame(len, rs, $urandom_range(0, 1), 2);
         idle($urandom_range(0, 4), 0);
         if ($urandom_range(0, 2) == 0) cycle(0, 0, 0, 1);
      end
      rand_rd = 1'b0;

      // counter saturation
      for (int f = 0; f < 260; f++) send_frame(2, -1, 0, 0);
      check_eq("err_sat", err_cnt, 255);
      for (int f = 0; f < 258; f++) send_frame(PN, -1, 0, 0);
      check_eq("fcnt_sat", frame_cnt, 255);
      check_eq("exp_q_empty", exp_q.size(), 0);

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
